multi_timer: RTL and testbench

Parametrised, multi-channel successor of the single 16-bit countdown timer. Holds CHANNELS independent down-counters of WIDTH bits, clocked by a shared programmable prescaler. Each channel runs one-shot or periodic (auto-reload), can be stopped, and reports busy plus a one-cycle expiry pulse. Sits beside the control logic as a general-purpose timeout/tick source.

---
 rtl/multi_timer.sv | 57 +++++
 tb/tb_multi_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent WIDTH-bit down-counters sharing one programmable prescaler.
// Each channel is one-shot or auto-reload, stoppable, and reports busy plus a one-cycle expiry pulse.
module multi_timer #(
  parameter int WIDTH          = 16,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          cycles,
  input  logic                      periodic,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS*WIDTH-1:0] count
);
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic                      w_tick;
  // >= rather than == so lowering prescale below pcnt cannot lock the prescaler up
  assign w_tick = r_pcnt >= prescale;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_pcnt <= '0;
    else          r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_exp;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_cnt    <= '0;
        r_reload <= '0;
        r_mode   <= 1'b0;
        r_exp    <= 1'b0;
      end else begin
        r_exp <= 1'b0;
        if (stop[g]) begin
          r_cnt  <= '0;
          r_mode <= 1'b0;
        end else if (load[g]) begin
          r_cnt    <= cycles;
          r_reload <= cycles;
          r_mode   <= periodic;
        end else if (w_tick && r_cnt == WIDTH'(1)) begin
          r_exp <= 1'b1;
          r_cnt <= r_mode ? r_reload : '0;
        end else if (w_tick && r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    assign busy[g]                  = r_cnt != '0;
    assign expired[g]               = r_exp;
    assign count[g*WIDTH +: WIDTH]  = r_cnt;
  end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: scoreboard bench for multi_timer; a cycle model queues expected outputs per edge,
// and directed checks cover reset, one-shot, periodic, prescaler, collisions and edge values.
module tb_multi_timer;
  localparam int W = 16;
  localparam int C = 4;
  localparam int P = 8;
  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [C-1:0]   load = '0;
  logic [C-1:0]   stop = '0;
  logic [W-1:0]   cycles = '0;
  logic           periodic = 1'b0;
  logic [P-1:0]   prescale = '0;
  logic [C-1:0]   busy;
  logic [C-1:0]   expired;
  logic [C*W-1:0] count;
  multi_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE_WIDTH(P)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .cycles(cycles), .periodic(periodic),
    .stop(stop), .prescale(prescale), .busy(busy), .expired(expired), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [C-1:0]   busy;
    logic [C-1:0]   exp;
    logic [C*W-1:0] count;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] m_cnt [C];
  logic [W-1:0] m_rel [C];
  logic         m_mode [C];
  logic [C-1:0] m_exp;
  logic [P-1:0] m_pcnt;
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] cnt_of(input int ch);
    return count[ch*W +: W];
  endfunction
  task automatic model_reset;
    for (int i = 0; i < C; i++) begin
      m_cnt[i] = '0;
      m_rel[i] = '0;
      m_mode[i] = 1'b0;
    end
    m_exp = '0;
    m_pcnt = '0;
  endtask
  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic [C-1:0] ld, input logic [W-1:0] cy, input logic per,
                      input logic [C-1:0] st);
    exp_t e;
    exp_t g;
    logic tick;
    load = ld;
    cycles = cy;
    periodic = per;
    stop = st;
    tick = m_pcnt >= prescale;
    m_pcnt = tick ? '0 : m_pcnt + 1'b1;
    for (int i = 0; i < C; i++) begin
      m_exp[i] = 1'b0;
      if (st[i]) begin
        m_cnt[i] = '0;
        m_mode[i] = 1'b0;
      end else if (ld[i]) begin
        m_cnt[i] = cy;
        m_rel[i] = cy;
        m_mode[i] = per;
      end else if (tick && m_cnt[i] != 0) begin
        if (m_cnt[i] == 1) begin
          m_exp[i] = 1'b1;
          m_cnt[i] = m_mode[i] ? m_rel[i] : '0;
        end else m_cnt[i] = m_cnt[i] - 1'b1;
      end
      e.busy[i] = m_cnt[i] != 0;
      e.count[i*W +: W] = m_cnt[i];
    end
    e.exp = m_exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    load = '0;
    stop = '0;
    cycles = '0;
    periodic = 1'b0;
    if (sb.size() == 0) check("sb_underflow", 1, 0);
    else begin
      g = sb.pop_front();
      check("busy", busy, g.busy);
      check("expired", expired, g.exp);
      check("count", count, g.count);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, '0);
  endtask
  initial begin
    int dur, nexp, t, t1, t2;
    logic [W-1:0] prev;
    logic all_busy;
    model_reset();
    #2;
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_expired", expired, 0);
    #10 reset_n = 1'b1;
    idle(2);
    // Asynchronous reset in the middle of a count
    step(4'b0001, 16'd10, 1'b0, '0);
    idle(3);
    check("pre_rst_count7", cnt_of(0), 7);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_count", count, 0);
    check("async_rst_expired", expired, 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(4);
    check("post_rst_idle", count, 0);
    // One-shot, prescale 0
    step(4'b0010, 16'd5, 1'b0, '0);
    dur = 0;
    nexp = 0;
    repeat (8) begin
      if (busy[1]) dur++;
      step('0, '0, 1'b0, '0);
      if (expired[1]) nexp++;
    end
    check("oneshot_busy_cycles", dur, 5);
    check("oneshot_pulses", nexp, 1);
    // Periodic, reload 3, then stop
    step(4'b0100, 16'd3, 1'b1, '0);
    nexp = 0;
    all_busy = 1'b1;
    repeat (12) begin
      step('0, '0, 1'b0, '0);
      if (expired[2]) nexp++;
      if (!busy[2]) all_busy = 1'b0;
    end
    check("periodic_pulses", nexp, 4);
    check("periodic_busy_steady", all_busy, 1);
    step('0, '0, 1'b0, 4'b0100);
    check("periodic_stop_count", cnt_of(2), 0);
    nexp = 0;
    repeat (6) begin
      step('0, '0, 1'b0, '0);
      if (expired[2]) nexp++;
    end
    check("stopped_no_pulse", nexp, 0);
    // Prescaler = 3: ticks every 4 cycles
    prescale = 8'd3;
    step(4'b0001, 16'd2, 1'b0, '0);
    dur = 0;
    t1 = -1;
    t2 = -1;
    t = 0;
    prev = cnt_of(0);
    repeat (12) begin
      if (busy[0]) dur++;
      step('0, '0, 1'b0, '0);
      t++;
      if (cnt_of(0) != prev) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
      prev = cnt_of(0);
    end
    check("psc_busy_in_range", dur >= 5 && dur <= 8, 1);
    check("psc_tick_spacing", t2 - t1, 4);
    prescale = 8'd0;
    idle(2);
    // Reload on the terminal edge
    step(4'b1000, 16'd2, 1'b0, '0);
    step('0, '0, 1'b0, '0);
    check("col_pre_count1", cnt_of(3), 1);
    step(4'b1000, 16'd9, 1'b0, '0);
    check("col_load_count", cnt_of(3), 9);
    check("col_load_nopulse", expired[3], 0);
    idle(8);
    check("col_pre_stop_count1", cnt_of(3), 1);
    step('0, '0, 1'b0, 4'b1000);
    check("col_stop_count", cnt_of(3), 0);
    check("col_stop_nopulse", expired[3], 0);
    step(4'b1000, 16'd5, 1'b0, '0);
    step(4'b1000, 16'd7, 1'b0, 4'b1000);
    check("stop_beats_load", cnt_of(3), 0);
    // Mixed simultaneous activity across channels
    step(4'b0011, 16'd4, 1'b1, '0);
    idle(2);
    step(4'b0100, 16'd6, 1'b0, 4'b0001);
    idle(10);
    step('0, '0, 1'b0, 4'b0010);
    idle(2);
    // Edge values: load 0 and load max
    step(4'b0001, 16'd0, 1'b0, '0);
    check("load0_busy", busy[0], 0);
    idle(2);
    check("load0_nopulse", expired[0], 0);
    step(4'b0001, 16'hFFFF, 1'b0, '0);
    dur = 0;
    nexp = 0;
    repeat (65540) begin
      if (busy[0]) dur++;
      step('0, '0, 1'b0, '0);
      if (expired[0]) nexp++;
    end
    check("max_busy_cycles", dur, 65535);
    check("max_pulses", nexp, 1);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
